// File: rtl/shop_v.sv
// Three-lane ASCII item-code case flipper.
// Registers the flipped code, an illegal flag and an accept count.
module shop_v #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic [23:0]      i_code,
    output logic [23:0]      o_f,
    output logic             o_err,
    output logic [CNT_W-1:0] o_cnt
);

    logic [2:0]  en;
    logic [23:0] f_nxt;
    logic [2:0]  ill;
    logic        acc;

    assign en  = {c, b, a};
    assign acc = (|en) && !(|ill);

    // Per-lane classify and transform; disabled lanes pass through.
    always_comb begin
        logic [7:0] ch;
        ch    = '0;
        f_nxt = i_code;
        ill   = '0;
        for (int i = 0; i < 3; i++) begin
            ch = i_code[8*i +: 8];
            if (en[i]) begin
                unique case (1'b1)
                    (ch >= 8'h41 && ch <= 8'h5A):
                        f_nxt[8*i +: 8] = ch + 8'h20;
                    (ch >= 8'h61 && ch <= 8'h7A):
                        f_nxt[8*i +: 8] = ch - 8'h20;
                    (ch >= 8'h30 && ch <= 8'h39):
                        f_nxt[8*i +: 8] = ch;
                    default: begin
                        f_nxt[8*i +: 8] = 8'h3F;
                        ill[i]          = 1'b1;
                    end
                endcase
            end
        end
    end

    // Output registers and wrapping accept counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_f   <= '0;
            o_err <= 1'b0;
            o_cnt <= '0;
        end else begin
            o_f   <= f_nxt;
            o_err <= |ill;
            if (acc) begin
                o_cnt <= o_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_shop_v.sv
// Directed bench for shop_v.
// Hand-computed vectors checked by immediate assertions.
module tb_shop_v;

    logic        clk;
    logic        rst_n;
    logic        a, b, c;
    logic [23:0] code;
    logic [23:0] f;
    logic        err;
    logic [7:0]  cnt;

    int total = 0;
    int bad   = 0;

    shop_v #(.CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .i_code  (code),
        .o_f     (f),
        .o_err   (err),
        .o_cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] ef,
                       input logic ee, input logic [7:0] ec);
        total++;
        assert (f === ef) else begin
            bad++;
            $error("FAIL %s o_f got=%h exp=%h", tag, f, ef);
        end
        total++;
        assert (err === ee) else begin
            bad++;
            $error("FAIL %s o_err got=%b exp=%b", tag, err, ee);
        end
        total++;
        assert (cnt === ec) else begin
            bad++;
            $error("FAIL %s o_cnt got=%0d exp=%0d", tag, cnt, ec);
        end
    endtask

    task automatic step(input logic [2:0] e, input logic [23:0] v);
        {c, b, a} = e;
        code      = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {c, b, a} = 3'b000;
        code = 24'h0;
        #2;
        chk("reset", 24'h000000, 1'b0, 8'd0);
        rst_n = 1'b1;

        step(3'b111, 24'h434241); chk("abc1", 24'h636261, 1'b0, 8'd1);
        step(3'b111, 24'h434242); chk("abc2", 24'h636262, 1'b0, 8'd2);
        step(3'b111, 24'h434243); chk("abc3", 24'h636263, 1'b0, 8'd3);
        step(3'b111, 24'h434244); chk("abc4", 24'h636264, 1'b0, 8'd4);

        step(3'b110, 24'h434241); chk("a_off", 24'h636241, 1'b0, 8'd5);
        step(3'b000, 24'h434241); chk("none", 24'h434241, 1'b0, 8'd5);

        step(3'b111, 24'h2A6131); chk("ill", 24'h3F4131, 1'b1, 8'd5);
        step(3'b011, 24'h2A6131); chk("c_off", 24'h2A4131, 1'b0, 8'd6);

        step(3'b111, 24'h605B40); chk("bnd_lo", 24'h3F3F3F, 1'b1, 8'd6);
        step(3'b111, 24'h3A2F7B); chk("bnd_hi", 24'h3F3F3F, 1'b1, 8'd6);
        step(3'b111, 24'h615A41); chk("ok_1", 24'h417A61, 1'b0, 8'd7);
        step(3'b111, 24'h39307A); chk("ok_2", 24'h39305A, 1'b0, 8'd8);
        step(3'b110, 24'h4142FF); chk("dis_ff", 24'h6162FF, 1'b0, 8'd9);
        step(3'b111, 24'h000000); chk("nul", 24'h3F3F3F, 1'b1, 8'd9);
        step(3'b100, 24'h7A8000); chk("c_only", 24'h5A8000, 1'b0, 8'd10);

        // Async reset between edges, then held across an edge.
        step(3'b111, 24'h434241); chk("pre_rst", 24'h636261, 1'b0, 8'd11);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 24'h000000, 1'b0, 8'd0);
        {c, b, a} = 3'b111;
        code = 24'h434241;
        @(posedge clk);
        #1 chk("rst_edge", 24'h000000, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b111, 24'h7A6130); chk("post_rst", 24'h5A4130, 1'b0, 8'd1);

        // Counter wrap from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 255; i++) step(3'b111, 24'h393939);
        chk("cnt_255", 24'h393939, 1'b0, 8'd255);
        step(3'b001, 24'h000041);
        chk("cnt_wrap", 24'h000061, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
